ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Fetch stage directly downstream of the instruction-cache tile.
- Drives the fetch PC into the cache and consumes the 48-bit instruction window plus its valid flag.
- Determines each instruction's length (16 or 32 bit) and advances the PC by that length.
- Buffers fetched instructions in a 2-entry queue feeding decode, with stall back-pressure and branch redirect/flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bit 0 is ignored and forced to 0.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- icPc  out  32  fetch address to the I-cache; combinationally equal to the internal PC register.
- icVal  in  48  instruction window at icPc; halfword 0 = bits [15:0], halfword 1 = bits [31:16].
- icOK  in  1  icVal is valid this cycle.
- brTaken  in  1  redirect request from a later stage.
- brPc  in  32  redirect target.
- idStall  in  1  decode cannot accept this cycle.
- idValid  out  1  queue head is valid.
- idOp  out  32  head opcode; 16-bit ops are {16'h0000, hw0}; 32-bit ops are {hw0, hw1}.
- idPc  out  32  PC of the head instruction.
- idLen  out  1  head length: 0 = 16 bit, 1 = 32 bit.

Behaviour:
- Reset:
  - pc = RESET_PC & ~1.
  - Queue count = 0, so idValid = 0.
  - idOp, idPc and idLen = 0.
- Length decode:
  - 32-bit iff hw0[15:12] == 4'h8 and hw0[11:10] == 2'b11.
  - All other encodings are 16-bit.
  - Bits [47:32] of icVal are unused by this block.
- Queue:
  - 2-entry FIFO; each entry holds op, pc, len.
  - Outputs come directly from head registers with no combinational path from icVal.
- pop = idValid & ~idStall.
- push = icOK & ~brTaken & (count < 2 | pop).
- On push:
  - Entry gets {op, pc, len}.
  - pc <= pc + 2 (16-bit) or pc + 4 (32-bit), modulo 2^32. 32'hFFFF_FFFE + 2 wraps to 0.
- Simultaneous push and pop:
  - count unchanged.
  - When count == 1, the pushed entry becomes the head on the next cycle.
- Full (count == 2) with no pop: no push, pc held, icPc stable.
- Empty: idValid = 0 and idOp/idPc/idLen hold their last values.
- Redirect (brTaken = 1) has top priority:
  - Next cycle count = 0, so idValid = 0, even if idStall = 1.
  - pc <= brPc & ~1.
  - Any icOK in the same cycle is discarded.
  - Back-to-back redirects: the last one wins.
- icOK = 0 (cache miss): no push, pc held. The cache refills autonomously while icPc stays constant.
- Latency:
  - Instruction at PC appears on idValid/idOp one cycle after the cycle in which icOK was high at that PC.
  - First fetch after a redirect: idValid no earlier than 2 cycles after brTaken.
- Reset mid-operation: queue cleared and pc = RESET_PC, regardless of brTaken, icOK or idStall.

Optional Feature:
- Macro: IFETCH_PERFCNT_EN.
- Defined:
  - Adds output port perfMissCyc (32 bit): increments each cycle with icOK = 0 and count < 2.
  - Adds output port perfFlushCnt (32 bit): increments each cycle brTaken = 1.
  - Both counters are cleared by reset and saturate at 32'hFFFF_FFFF.
- Not defined: neither port exists and there is no counter logic.

Test Plan:
- Reset with RESET_PC = 32'h0000_1000:
  - icPc = 32'h1000 and idValid = 0 while reset is high.
  - icPc stays 32'h1000 the first cycle after release.
- Two 16-bit ops with icOK = 1 and idStall = 0:
  - icVal[15:0] = 16'h6123 at 0x1000 -> idOp = 32'h0000_6123, idPc = 32'h1000, idLen = 0; icPc becomes 32'h1002.
  - Next window 16'h7001 -> idPc = 32'h1002, icPc = 32'h1004.
- 32-bit op: hw0 = 16'h8C12, hw1 = 16'h3456 at 0x1004 -> idOp = 32'h8C12_3456, idLen = 1, icPc = 32'h1008.
- Stall and full:
  - idStall = 1 with icOK = 1 for 4 cycles -> count saturates at 2 and icPc holds at 32'h1004 after two pushes from 0x1000.
  - Release idStall -> ops at 0x1000 and 0x1002 drain in order on consecutive cycles.
- Redirect while full and stalled: brTaken = 1, brPc = 32'h2001 -> next cycle idValid = 0 and icPc = 32'h2000; the queued 0x1000/0x1002 entries never appear.
- Miss and wrap:
  - icOK = 0 for 5 cycles at 0x2000 -> icPc constant and idValid = 0.
  - Separate case: pc = 32'hFFFF_FFFE with a 16-bit op -> icPc becomes 32'h0000_0000.

Source files
------------

// File: rtl/ifetch_queue.sv
// Fetch stage: drives the PC into the I-cache, decodes 16/32-bit length, and buffers ops in a 2-entry queue.
// Optional performance counters are enabled by defining IFETCH_PERFCNT_EN.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] icPc,
    input  logic [47:0] icVal,
    input  logic        icOK,
    input  logic        brTaken,
    input  logic [31:0] brPc,
    input  logic        idStall,
    output logic        idValid,
    output logic [31:0] idOp,
    output logic [31:0] idPc,
    output logic        idLen
`ifdef IFETCH_PERFCNT_EN
    ,
    output logic [31:0] perfMissCyc,
    output logic [31:0] perfFlushCnt
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:1], 1'b0};

    logic [31:0] pc;
    logic [1:0]  count;
    logic [31:0] tail_op;
    logic [31:0] tail_pc;
    logic        tail_len;

    logic [15:0] hw0;
    logic [15:0] hw1;
    logic        is32;
    logic [31:0] new_op;
    logic [31:0] pc_next;
    logic        pop;
    logic        push;
    logic        unused_hi;

    assign hw0       = icVal[15:0];
    assign hw1       = icVal[31:16];
    assign unused_hi = ^icVal[47:32];

    // A 32-bit op is marked by the 4'h8 major nibble with both bits [11:10] set.
    assign is32    = (hw0[15:12] == 4'h8) && (hw0[11:10] == 2'b11);
    assign new_op  = is32 ? {hw0, hw1} : {16'h0000, hw0};
    assign pc_next = pc + (is32 ? 32'd4 : 32'd2);

    // Decode handshake: the head transfers on a cycle where idValid is high and idStall is low;
    // the cache side transfers when icOK is high and the queue has (or is making) room.
    assign pop  = idValid & ~idStall;
    assign push = icOK & ~brTaken & ((count < 2'd2) | pop);

    assign icPc    = pc;
    assign idValid = (count != 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= RESET_PC_ALIGNED;
            count    <= 2'd0;
            idOp     <= 32'h0;
            idPc     <= 32'h0;
            idLen    <= 1'b0;
            tail_op  <= 32'h0;
            tail_pc  <= 32'h0;
            tail_len <= 1'b0;
        end else if (brTaken) begin
            count <= 2'd0;
            pc    <= {brPc[31:1], 1'b0};
        end else begin
            if (push) begin
                pc <= pc_next;
            end
            case (count)
                2'd0: begin
                    if (push) begin
                        idOp  <= new_op;
                        idPc  <= pc;
                        idLen <= is32;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        idOp  <= new_op;
                        idPc  <= pc;
                        idLen <= is32;
                    end else if (push) begin
                        tail_op  <= new_op;
                        tail_pc  <= pc;
                        tail_len <= is32;
                        count    <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a push can only ride along with a pop, shifting tail into head.
                    if (pop) begin
                        idOp  <= tail_op;
                        idPc  <= tail_pc;
                        idLen <= tail_len;
                        if (push) begin
                            tail_op  <= new_op;
                            tail_pc  <= pc;
                            tail_len <= is32;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef IFETCH_PERFCNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perfMissCyc  <= 32'h0;
            perfFlushCnt <= 32'h0;
        end else begin
            if (!icOK && (count < 2'd2) && (perfMissCyc != 32'hFFFF_FFFF)) begin
                perfMissCyc <= perfMissCyc + 32'd1;
            end
            if (brTaken && (perfFlushCnt != 32'hFFFF_FFFF)) begin
                perfFlushCnt <= perfFlushCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: expected head entries go into a queue, a negedge monitor checks each consumed op.
module tb_ifetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] icPc;
    logic [47:0] icVal;
    logic        icOK;
    logic        brTaken;
    logic [31:0] brPc;
    logic        idStall;
    logic        idValid;
    logic [31:0] idOp;
    logic [31:0] idPc;
    logic        idLen;
`ifdef IFETCH_PERFCNT_EN
    logic [31:0] perfMissCyc;
    logic [31:0] perfFlushCnt;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;
    logic [64:0] exp_q[$];

    always #5 clock = ~clock;

    ifetch_queue #(.RESET_PC(32'h0000_1000)) dut (
        .clock   (clock),
        .reset   (reset),
        .icPc    (icPc),
        .icVal   (icVal),
        .icOK    (icOK),
        .brTaken (brTaken),
        .brPc    (brPc),
        .idStall (idStall),
        .idValid (idValid),
        .idOp    (idOp),
        .idPc    (idPc),
        .idLen   (idLen)
`ifdef IFETCH_PERFCNT_EN
        ,
        .perfMissCyc  (perfMissCyc),
        .perfFlushCnt (perfFlushCnt)
`endif
    );

    function automatic logic [64:0] ent(input logic [31:0] op, input logic [31:0] pc, input logic len);
        return {len, pc, op};
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Drive one cycle of inputs; record the hand-computed entry that should be enqueued.
    task automatic step(input logic ok, input logic [47:0] val, input logic br, input logic [31:0] bpc,
                        input logic stall, input logic exp_push, input logic [64:0] exp_e);
        icOK    = ok;
        icVal   = val;
        brTaken = br;
        brPc    = bpc;
        idStall = stall;
        @(posedge clock);
        if (br) exp_q.delete();
        if (exp_push) exp_q.push_back(exp_e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 48'h0, 1'b0, 32'h0, 1'b0, 1'b0, 65'h0);
    endtask

    // Monitor: every transfer to decode must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && idValid && !idStall) begin
            check_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_op: got op=%h pc=%h len=%b with no entry expected", idOp, idPc, idLen);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                if ({idLen, idPc, idOp} === e) pass_cnt++;
                else $display("FAIL head_entry: got op=%h pc=%h len=%b expected op=%h pc=%h len=%b",
                              idOp, idPc, idLen, e[31:0], e[63:32], e[64]);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        icOK    = 1'b0;
        icVal   = 48'h0;
        brTaken = 1'b0;
        brPc    = 32'h0;
        idStall = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk32("reset_icPc", icPc, 32'h0000_1000);
        chk1("reset_idValid", idValid, 1'b0);
        chk32("reset_idOp", idOp, 32'h0);
        chk32("reset_idPc", idPc, 32'h0);
        chk1("reset_idLen", idLen, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk32("release_icPc", icPc, 32'h0000_1000);
        chk1("release_idValid", idValid, 1'b0);

        // Two 16-bit ops then one 32-bit op, no stall
        step(1'b1, 48'h6123, 1'b0, 32'h0, 1'b0, 1'b1, ent(32'h0000_6123, 32'h1000, 1'b0));
        chk32("icPc_after_16a", icPc, 32'h1002);
        chk1("latency_valid", idValid, 1'b1);
        step(1'b1, 48'h7001, 1'b0, 32'h0, 1'b0, 1'b1, ent(32'h0000_7001, 32'h1002, 1'b0));
        chk32("icPc_after_16b", icPc, 32'h1004);
        step(1'b1, 48'h0000_3456_8C12, 1'b0, 32'h0, 1'b0, 1'b1, ent(32'h8C12_3456, 32'h1004, 1'b1));
        chk32("icPc_after_32", icPc, 32'h1008);
        idle(1);
        chk1("drained_valid", idValid, 1'b0);
        idle(1);

        // Stall until full, then drain with a push riding on the first pop
        step(1'b0, 48'h0, 1'b1, 32'h1000, 1'b0, 1'b0, 65'h0);
        chk32("redirect_icPc", icPc, 32'h1000);
        step(1'b1, 48'h1111, 1'b0, 32'h0, 1'b1, 1'b1, ent(32'h0000_1111, 32'h1000, 1'b0));
        step(1'b1, 48'h2222, 1'b0, 32'h0, 1'b1, 1'b1, ent(32'h0000_2222, 32'h1002, 1'b0));
        chk32("full_icPc0", icPc, 32'h1004);
        step(1'b1, 48'h3333, 1'b0, 32'h0, 1'b1, 1'b0, 65'h0);
        chk32("full_icPc1", icPc, 32'h1004);
        step(1'b1, 48'h3333, 1'b0, 32'h0, 1'b1, 1'b0, 65'h0);
        chk32("full_icPc2", icPc, 32'h1004);
        chk1("full_valid", idValid, 1'b1);
        step(1'b1, 48'h3333, 1'b0, 32'h0, 1'b0, 1'b1, ent(32'h0000_3333, 32'h1004, 1'b0));
        chk1("drain_valid1", idValid, 1'b1);
        chk32("pushpop_icPc", icPc, 32'h1006);
        idle(1);
        chk1("drain_valid2", idValid, 1'b1);
        idle(1);
        chk1("drain_empty", idValid, 1'b0);
        chk32("hold_idOp", idOp, 32'h0000_3333);
        chk32("hold_idPc", idPc, 32'h1004);

        // Redirect while full and stalled: queued entries must vanish
        step(1'b0, 48'h0, 1'b1, 32'h1000, 1'b0, 1'b0, 65'h0);
        step(1'b1, 48'h4444, 1'b0, 32'h0, 1'b1, 1'b1, ent(32'h0000_4444, 32'h1000, 1'b0));
        step(1'b1, 48'h5555, 1'b0, 32'h0, 1'b1, 1'b1, ent(32'h0000_5555, 32'h1002, 1'b0));
        step(1'b1, 48'h6666, 1'b1, 32'h2001, 1'b1, 1'b0, 65'h0);
        chk1("flush_valid", idValid, 1'b0);
        chk32("flush_icPc", icPc, 32'h2000);

        // Cache miss: pc held, nothing delivered
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk32("miss_icPc", icPc, 32'h2000);
            chk1("miss_valid", idValid, 1'b0);
        end

        // Length-decode boundaries
        step(1'b1, 48'h0000_ABCD_8F00, 1'b0, 32'h0, 1'b0, 1'b1, ent(32'h8F00_ABCD, 32'h2000, 1'b1));
        chk32("len32_icPc", icPc, 32'h2004);
        step(1'b1, 48'h0000_ABCD_8800, 1'b0, 32'h0, 1'b0, 1'b1, ent(32'h0000_8800, 32'h2004, 1'b0));
        chk32("len16_8800_icPc", icPc, 32'h2006);
        step(1'b1, 48'h0000_ABCD_9C00, 1'b0, 32'h0, 1'b0, 1'b1, ent(32'h0000_9C00, 32'h2006, 1'b0));
        chk32("len16_9C00_icPc", icPc, 32'h2008);
        idle(2);

        // Back-to-back redirects with icOK high: last target wins, fetch discarded
        step(1'b1, 48'h1234, 1'b1, 32'h3000, 1'b0, 1'b0, 65'h0);
        step(1'b1, 48'h1234, 1'b1, 32'h4000, 1'b0, 1'b0, 65'h0);
        chk32("b2b_icPc", icPc, 32'h4000);
        chk1("b2b_valid", idValid, 1'b0);
        step(1'b1, 48'h1234, 1'b0, 32'h0, 1'b0, 1'b1, ent(32'h0000_1234, 32'h4000, 1'b0));
        chk32("b2b_fetch_icPc", icPc, 32'h4002);

        // PC wrap
        step(1'b0, 48'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 65'h0);
        chk32("wrap_start_icPc", icPc, 32'hFFFF_FFFE);
        step(1'b1, 48'h0042, 1'b0, 32'h0, 1'b0, 1'b1, ent(32'h0000_0042, 32'hFFFF_FFFE, 1'b0));
        chk32("wrap_icPc", icPc, 32'h0000_0000);
        idle(2);

        // Reset mid-operation overrides redirect, fetch and stall
        step(1'b1, 48'h0055, 1'b0, 32'h0, 1'b1, 1'b1, ent(32'h0000_0055, 32'h0, 1'b0));
        icOK    = 1'b1;
        brTaken = 1'b1;
        brPc    = 32'h5000;
        idStall = 1'b1;
        reset   = 1'b1;
        @(posedge clock);
        exp_q.delete();
        #1;
        chk32("midreset_icPc", icPc, 32'h0000_1000);
        chk1("midreset_valid", idValid, 1'b0);
        reset = 1'b0;
        idle(2);
        chk1("midreset_stays_empty", idValid, 1'b0);

        check_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL leftover_entries: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
